// File: rtl/jump_sequencer.sv
// Navigation jump sequencer: selects the position-integration mode each clock and
// sequences jump requests through warp charge, a single-cycle jump and a cooldown.
module jump_sequencer #(
  parameter int K               = 16,
  parameter int CHARGE_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           nav_reset,
  input  logic           jump_req,
  input  logic [3*K-1:0] jump_target,
  input  logic           abort,
  output logic [3:0]     pos_mode,
  output logic [3*K-1:0] jump_position,
  output logic           jump_ack,
  output logic           jump_done,
  output logic           aborted,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_ZERO,
    S_IDLE,
    S_CHARGE,
    S_JUMP,
    S_COOLDOWN
  } state_t;

  localparam logic [7:0] CHARGE_LOAD   = 8'(CHARGE_CYCLES - 1);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYCLES - 1);

  localparam logic [3:0] MODE_ZERO     = 4'b0001;
  localparam logic [3:0] MODE_SUBLIGHT = 4'b0010;
  localparam logic [3:0] MODE_JUMP     = 4'b0100;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept;
  logic       abort_hit;
  logic [3:0] mode_nxt;
  logic       busy_nxt;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    abort_hit = 1'b0;

    if (nav_reset) begin
      state_nxt = S_ZERO;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_ZERO: state_nxt = S_IDLE;
        S_IDLE: begin
          if (jump_req) begin
            accept    = 1'b1;
            state_nxt = S_CHARGE;
            cnt_nxt   = CHARGE_LOAD;
          end
        end
        S_CHARGE: begin
          // Abort outranks the final charge cycle, so a late abort still cancels.
          if (abort) begin
            abort_hit = 1'b1;
            state_nxt = S_IDLE;
          end else if (cnt == 8'd0) begin
            state_nxt = S_JUMP;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        S_JUMP: begin
          state_nxt = S_COOLDOWN;
          cnt_nxt   = COOLDOWN_LOAD;
        end
        S_COOLDOWN: begin
          if (cnt == 8'd0) state_nxt = S_IDLE;
          else             cnt_nxt   = cnt - 8'd1;
        end
        default: begin
          state_nxt = S_ZERO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    mode_nxt = MODE_SUBLIGHT;
    busy_nxt = 1'b0;
    unique case (state_nxt)
      S_ZERO:     mode_nxt = MODE_ZERO;
      S_JUMP:     begin mode_nxt = MODE_JUMP; busy_nxt = 1'b1; end
      S_CHARGE,
      S_COOLDOWN: busy_nxt = 1'b1;
      default:    mode_nxt = MODE_SUBLIGHT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_ZERO;
      cnt           <= '0;
      pos_mode      <= MODE_ZERO;
      busy          <= 1'b0;
      jump_position <= '0;
      jump_ack      <= 1'b0;
      jump_done     <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pos_mode  <= mode_nxt;
      busy      <= busy_nxt;
      jump_ack  <= accept;
      jump_done <= (state_nxt == S_JUMP);
      aborted   <= abort_hit;
      if (accept) jump_position <= jump_target;
    end
  end

endmodule
